button_event_scheduler: RTL and testbench

// Turns debounced button levels into discrete events: PRESS, RELEASE, LONG
// (held past a threshold) and REPEAT (periodic while held after LONG).

---
 rtl/btn_evt_pkg.sv | 29 ++
 rtl/button_event_scheduler_if.sv | 33 +++
 rtl/button_event_fsm.sv | 139 +++++++++++++
 rtl/button_event_scheduler.sv | 100 ++++++++++
 tb/tb_button_event_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/btn_evt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btn_evt_pkg
//  Purpose  : Shared event codes, per-button FSM states and width helper for
//             the button event scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package btn_evt_pkg;

    // Event type codes carried on ev_type
    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
    localparam logic [1:0] EV_REPEAT  = 2'd3;

    // Per-button state encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_e;

    // Button index width; a single button still needs one id bit
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : btn_evt_pkg
`default_nettype wire

// File: rtl/button_event_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_scheduler_if
//  Purpose  : Valid/ready event stream produced by the button event scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface button_event_scheduler_if #(
    parameter int ID_W = 2
) ();

    logic            ev_valid;
    logic            ev_ready;
    logic [ID_W-1:0] ev_id;
    logic [1:0]      ev_type;

    // Event producer
    modport master (
        output ev_valid,
        output ev_id,
        output ev_type,
        input  ev_ready
    );

    // Event consumer
    modport slave (
        input  ev_valid,
        input  ev_id,
        input  ev_type,
        output ev_ready
    );

endinterface : button_event_scheduler_if
`default_nettype wire

// File: rtl/button_event_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_fsm
//  Purpose  : One button: edge detect, PRESS/RELEASE/LONG/REPEAT FSM with
//             hold counter, single-entry event slot and sticky overrun flag.
//  Revision : 1.0 - initial release
// ============================================================================
module button_event_fsm
    import btn_evt_pkg::*;
#(
    parameter int CNT_W         = 24,
    parameter int LONG_CYCLES   = 2**20,
    parameter int REPEAT_CYCLES = 2**18
) (
    input  wire logic       clk,
    input  wire logic       nrst,
    input  wire logic       ena_i,
    input  wire logic       btn_i,
    input  wire logic       grant_i,
    input  wire logic       ovr_clr_i,
    output logic            slot_valid_o,
    output logic [1:0]      slot_type_o,
    output logic            overrun_o
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam bit               REPEAT_ON   = (REPEAT_CYCLES > 0);
    localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_ON ? CNT_W'(REPEAT_CYCLES - 1) : '0;

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_prev_q;
    // Cleared by reset and set once the button is seen released, so a button
    // held through reset cannot produce a PRESS until it is pressed afresh.
    logic             armed_q;
    logic             slot_valid_q;
    logic [1:0]       slot_type_q;
    logic             overrun_q;

    logic             emit;
    logic [1:0]       emit_type;
    logic             drop;

    // Next-state, counter and event decision for this button
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_type = EV_PRESS;
        if (ena_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_i && !btn_prev_q && armed_q) begin
                        state_d   = ST_PRESSED;
                        cnt_d     = '0;
                        emit      = 1'b1;
                        emit_type = EV_PRESS;
                    end
                end
                ST_PRESSED: begin
                    if (!btn_i) begin
                        state_d   = ST_IDLE;
                        emit      = 1'b1;
                        emit_type = EV_RELEASE;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d   = ST_HELD;
                        cnt_d     = '0;
                        emit      = 1'b1;
                        emit_type = EV_LONG;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!btn_i) begin
                        state_d   = ST_IDLE;
                        emit      = 1'b1;
                        emit_type = EV_RELEASE;
                    end else if (REPEAT_ON) begin
                        if (cnt_q == REPEAT_LAST) begin
                            cnt_d     = '0;
                            emit      = 1'b1;
                            emit_type = EV_REPEAT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // An event is lost only when the slot is occupied and not being drained
    assign drop = emit && slot_valid_q && !grant_i;

    // FSM state, hold counter and button history; frozen while ena_i is low
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            btn_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else if (ena_i) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_prev_q <= btn_i;
            if (!btn_i) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Pending-event slot and sticky overrun; a new overrun beats a clear
    always_ff @(posedge clk) begin
        if (!nrst) begin
            slot_valid_q <= 1'b0;
            slot_type_q  <= EV_PRESS;
            overrun_q    <= 1'b0;
        end else begin
            if (emit && (!slot_valid_q || grant_i)) begin
                slot_valid_q <= 1'b1;
                slot_type_q  <= emit_type;
            end else if (grant_i) begin
                slot_valid_q <= 1'b0;
            end
            overrun_q <= (overrun_q && !ovr_clr_i) || drop;
        end
    end

    assign slot_valid_o = slot_valid_q;
    assign slot_type_o  = slot_type_q;
    assign overrun_o    = overrun_q;

endmodule : button_event_fsm
`default_nettype wire

// File: rtl/button_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_scheduler
//  Purpose  : Converts debounced button levels into PRESS/RELEASE/LONG/REPEAT
//             events and arbitrates them round-robin onto one valid/ready
//             event stream.
//  Revision : 1.0 - initial release
// ============================================================================
module button_event_scheduler
    import btn_evt_pkg::*;
#(
    parameter  int WIDTH         = 4,
    parameter  int CNT_W         = 24,
    parameter  int LONG_CYCLES   = 2**20,
    parameter  int REPEAT_CYCLES = 2**18,
    localparam int ID_W          = id_width(WIDTH)
) (
    input  wire logic               clk,
    input  wire logic               nrst,
    input  wire logic               ena_i,
    input  wire logic [WIDTH-1:0]   btn_i,
    button_event_scheduler_if.master ev_if,
    output logic      [WIDTH-1:0]   overrun_o,
    input  wire logic [WIDTH-1:0]   ovr_clr_i
);

    logic [WIDTH-1:0] slot_valid;
    logic [1:0]       slot_type [WIDTH];
    logic [WIDTH-1:0] grant;

    logic             ev_valid_q;
    logic [ID_W-1:0]  ev_id_q;
    logic [1:0]       ev_type_q;
    logic [ID_W-1:0]  rr_q;

    logic             load;
    logic             found;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  cand;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_btn
        button_event_fsm #(
            .CNT_W         (CNT_W),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_fsm (
            .clk          (clk),
            .nrst         (nrst),
            .ena_i        (ena_i),
            .btn_i        (btn_i[gi]),
            .grant_i      (grant[gi]),
            .ovr_clr_i    (ovr_clr_i[gi]),
            .slot_valid_o (slot_valid[gi]),
            .slot_type_o  (slot_type[gi]),
            .overrun_o    (overrun_o[gi])
        );
    end

    // Output register may take a new event when empty or being consumed
    assign load = !ev_valid_q || ev_if.ev_ready;

    // Round-robin search: first full slot starting just after the last grant
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= WIDTH; k++) begin
            cand = ID_W'((int'(rr_q) + k) % WIDTH);
            if (!found && slot_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign grant = (load && found) ? (WIDTH'(1) << gnt_idx) : '0;

    // Output event register and round-robin pointer; run regardless of ena_i
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            ev_type_q  <= EV_PRESS;
            rr_q       <= '0;
        end else if (load) begin
            ev_valid_q <= found;
            if (found) begin
                ev_id_q   <= gnt_idx;
                ev_type_q <= slot_type[gnt_idx];
                rr_q      <= gnt_idx;
            end
        end
    end

    assign ev_if.ev_valid = ev_valid_q;
    assign ev_if.ev_id    = ev_id_q;
    assign ev_if.ev_type  = ev_type_q;

endmodule : button_event_scheduler
`default_nettype wire

// File: tb/tb_button_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_event_scheduler
//  Purpose  : Directed self-checking bench; expected events (id, type, cycle
//             of handshake) are queued as stimulus is applied and popped as
//             the scheduler delivers them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_scheduler;
    import btn_evt_pkg::*;

    localparam int WIDTH = 4;
    localparam int ID_W  = 2;

    logic             clk     = 1'b0;
    logic             nrst    = 1'b0;
    logic             ena     = 1'b1;
    logic [WIDTH-1:0] btn     = '0;
    logic [WIDTH-1:0] ovr_clr = '0;
    logic [WIDTH-1:0] overrun;

    button_event_scheduler_if #(.ID_W(ID_W)) ev_if ();

    button_event_scheduler #(
        .WIDTH         (WIDTH),
        .CNT_W         (24),
        .LONG_CYCLES   (8),
        .REPEAT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .ena_i     (ena),
        .btn_i     (btn),
        .ev_if     (ev_if),
        .overrun_o (overrun),
        .ovr_clr_i (ovr_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      typ;
        int              at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    endtask

    task automatic push(input int id, input logic [1:0] typ, input int at);
        exp_t e;
        e.id  = ID_W'(id);
        e.typ = typ;
        e.at  = at;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every handshake must match the oldest expected event
    exp_t got;
    always @(negedge clk) begin
        if (nrst && ev_if.ev_valid && ev_if.ev_ready) begin
            check("event_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                check("ev_id",    32'(ev_if.ev_id),   32'(got.id));
                check("ev_type",  32'(ev_if.ev_type), 32'(got.typ));
                check("ev_cycle", 32'(cyc),           32'(got.at));
            end
        end
    end

    initial begin
        int e;
        ev_if.ev_ready = 1'b1;

        // Reset state
        tick(3);
        check("rst_ev_valid", 32'(ev_if.ev_valid), 32'd0);
        check("rst_ev_id",    32'(ev_if.ev_id),    32'd0);
        check("rst_ev_type",  32'(ev_if.ev_type),  32'd0);
        check("rst_overrun",  32'(overrun),        32'd0);
        nrst = 1'b1;
        tick(3);

        // Short press on button 1: PRESS then RELEASE, no LONG
        e = cyc;
        btn = 4'b0010;
        push(1, EV_PRESS, e + 2);
        tick(3);
        btn = 4'b0000;
        push(1, EV_RELEASE, e + 5);
        tick(4);

        // Long hold on button 0: PRESS, LONG, three REPEATs, RELEASE
        e = cyc;
        btn = 4'b0001;
        push(0, EV_PRESS,  e + 2);
        push(0, EV_LONG,   e + 10);
        push(0, EV_REPEAT, e + 14);
        push(0, EV_REPEAT, e + 18);
        push(0, EV_REPEAT, e + 22);
        tick(22);
        btn = 4'b0000;
        push(0, EV_RELEASE, e + 24);
        tick(4);

        // Tap button 3 so the round-robin pointer sits on id3
        e = cyc;
        btn = 4'b1000;
        push(3, EV_PRESS, e + 2);
        tick(1);
        btn = 4'b0000;
        push(3, EV_RELEASE, e + 3);
        tick(4);

        // All buttons at once: presses then releases both served 0,1,2,3
        e = cyc;
        btn = 4'hF;
        for (int i = 0; i < WIDTH; i++) push(i, EV_PRESS, e + 2 + i);
        tick(6);
        btn = 4'h0;
        for (int i = 0; i < WIDTH; i++) push(i, EV_RELEASE, e + 8 + i);
        tick(8);

        // Back-pressure on button 2: output holds, later events drop
        e = cyc;
        ev_if.ev_ready = 1'b0;
        btn = 4'b0100;
        tick(1);
        btn = 4'b0000;
        tick(1);
        check("bp_valid",   32'(ev_if.ev_valid), 32'd1);
        check("bp_id",      32'(ev_if.ev_id),    32'd2);
        check("bp_type",    32'(ev_if.ev_type),  32'(EV_PRESS));
        check("bp_ovr_0",   32'(overrun),        32'd0);
        tick(1);
        btn = 4'b0100;
        tick(1);
        check("bp_ovr_set", 32'(overrun), 32'b0100);
        btn = 4'b0000;
        ovr_clr = 4'b0100;
        tick(1);
        check("bp_ovr_setwins", 32'(overrun), 32'b0100);
        check("bp_hold_id",     32'(ev_if.ev_id),   32'd2);
        check("bp_hold_type",   32'(ev_if.ev_type), 32'(EV_PRESS));
        tick(1);
        check("bp_ovr_clr", 32'(overrun), 32'd0);
        ovr_clr = 4'b0000;
        push(2, EV_PRESS,   cyc);
        push(2, EV_RELEASE, cyc + 1);
        ev_if.ev_ready = 1'b1;
        tick(5);

        // Reset while button 0 is HELD and button 3 has overrun
        ev_if.ev_ready = 1'b0;
        btn = 4'b0001;
        tick(2);
        btn = 4'b1001;
        tick(1);
        btn = 4'b0001;
        tick(8);
        check("prerst_ovr",   32'(overrun),        32'b1000);
        check("prerst_valid", 32'(ev_if.ev_valid), 32'd1);
        nrst = 1'b0;
        tick(1);
        check("midrst_valid", 32'(ev_if.ev_valid), 32'd0);
        check("midrst_ovr",   32'(overrun),        32'd0);
        nrst = 1'b1;
        ev_if.ev_ready = 1'b1;
        tick(4);
        btn = 4'b0000;
        tick(6);

        // Enable stall of 10 cycles after PRESS delays LONG by 10 cycles
        e = cyc;
        btn = 4'b0010;
        push(1, EV_PRESS, e + 2);
        tick(1);
        ena = 1'b0;
        tick(10);
        ena = 1'b1;
        push(1, EV_LONG, e + 20);
        tick(10);
        btn = 4'b0000;
        push(1, EV_RELEASE, e + 23);
        tick(6);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_button_event_scheduler
`default_nettype wire
